// File: rtl/id_reg.sv
// ---------------------------------------------------------------------------
// id_reg : ID/EX pipeline register with RV32I field/immediate decode,
//          JAL target computation and load-use hazard detection.
//
// Ports
//   i_clk            clock, all state updates on rising edge
//   i_reset          synchronous active-high reset
//   i_stall          hold every output register
//   i_flush          replace captured instruction with a bubble
//   i_if_pc/insn/en  PC, instruction and valid from the IF/ID register
//   i_ex_load/ex_rd  EX stage holds a valid load, and its destination
//   o_id_*           registered decode results (pc, insn, en, rs1, rs2,
//                    rd, imm, op, illegal, br_taken, br_addr)
//   o_load_hazard    combinational stall request to IF/ID and PC logic
// ---------------------------------------------------------------------------
module id_reg (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_if_pc,
    input  logic [31:0] i_if_insn,
    input  logic        i_if_en,
    input  logic        i_ex_load,
    input  logic [4:0]  i_ex_rd,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_insn,
    output logic        o_id_en,
    output logic [4:0]  o_id_rs1,
    output logic [4:0]  o_id_rs2,
    output logic [4:0]  o_id_rd,
    output logic [31:0] o_id_imm,
    output logic [2:0]  o_id_op,
    output logic        o_id_illegal,
    output logic        o_id_br_taken,
    output logic [31:0] o_id_br_addr,
    output logic        o_load_hazard
);

    localparam logic [6:0]  OPC_OP     = 7'h33;
    localparam logic [6:0]  OPC_OP_IMM = 7'h13;
    localparam logic [6:0]  OPC_LOAD   = 7'h03;
    localparam logic [6:0]  OPC_STORE  = 7'h23;
    localparam logic [6:0]  OPC_BRANCH = 7'h63;
    localparam logic [6:0]  OPC_JAL    = 7'h6F;
    localparam logic [6:0]  OPC_JALR   = 7'h67;
    localparam logic [6:0]  OPC_LUI    = 7'h37;
    localparam logic [6:0]  OPC_AUIPC  = 7'h17;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm;
    logic [2:0]  w_op;
    logic        w_illegal;
    logic        w_is_jal;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic [31:0] w_jal_addr;
    logic        w_load_hazard;
    logic        w_bubble;

    logic [31:0] r_id_pc;
    logic [31:0] r_id_insn;
    logic        r_id_en;
    logic [4:0]  r_id_rs1;
    logic [4:0]  r_id_rs2;
    logic [4:0]  r_id_rd;
    logic [31:0] r_id_imm;
    logic [2:0]  r_id_op;
    logic        r_id_illegal;
    logic        r_id_br_taken;
    logic [31:0] r_id_br_addr;

    assign w_opcode = i_if_insn[6:0];
    assign w_rs1    = i_if_insn[19:15];
    assign w_rs2    = i_if_insn[24:20];

    assign w_imm_i = {{20{i_if_insn[31]}}, i_if_insn[31:20]};
    assign w_imm_s = {{20{i_if_insn[31]}}, i_if_insn[31:25], i_if_insn[11:7]};
    assign w_imm_b = {{19{i_if_insn[31]}}, i_if_insn[31], i_if_insn[7],
                      i_if_insn[30:25], i_if_insn[11:8], 1'b0};
    assign w_imm_u = {i_if_insn[31:12], 12'h000};
    assign w_imm_j = {{11{i_if_insn[31]}}, i_if_insn[31], i_if_insn[19:12],
                      i_if_insn[20], i_if_insn[30:21], 1'b0};

    always_comb begin
        w_op       = 3'd0;
        w_illegal  = 1'b0;
        w_imm      = 32'h0;
        w_rd       = i_if_insn[11:7];
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_is_jal   = 1'b0;
        unique case (w_opcode)
            OPC_OP: begin
                w_op       = 3'd1;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_OP_IMM: begin
                w_op       = 3'd2;
                w_imm      = w_imm_i;
                w_rs1_used = 1'b1;
            end
            OPC_LOAD: begin
                w_op       = 3'd3;
                w_imm      = w_imm_i;
                w_rs1_used = 1'b1;
            end
            OPC_STORE: begin
                w_op       = 3'd4;
                w_imm      = w_imm_s;
                w_rd       = 5'd0;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                w_op       = 3'd5;
                w_imm      = w_imm_b;
                w_rd       = 5'd0;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OPC_JAL: begin
                w_op     = 3'd6;
                w_imm    = w_imm_j;
                w_is_jal = 1'b1;
            end
            OPC_JALR: begin
                w_op       = 3'd6;
                w_imm      = w_imm_i;
                w_rs1_used = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_op  = 3'd7;
                w_imm = w_imm_u;
            end
            default: begin
                w_illegal = 1'b1;
                w_rd      = 5'd0;
            end
        endcase
    end

    // Target wraps modulo 2^32; carry out is deliberately dropped.
    assign w_jal_addr = i_if_pc + w_imm_j;

    // Evaluated on the incoming instruction independent of reset/stall/flush,
    // so the front end sees the request in the same cycle.
    assign w_load_hazard = i_if_en & i_ex_load & (i_ex_rd != 5'd0) &
                           ((w_rs1_used & (w_rs1 == i_ex_rd)) |
                            (w_rs2_used & (w_rs2 == i_ex_rd)));

    assign w_bubble = i_flush | w_load_hazard | ~i_if_en;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_id_pc       <= 32'h0;
            r_id_insn     <= NOP_INSN;
            r_id_en       <= 1'b0;
            r_id_rs1      <= 5'd0;
            r_id_rs2      <= 5'd0;
            r_id_rd       <= 5'd0;
            r_id_imm      <= 32'h0;
            r_id_op       <= 3'd0;
            r_id_illegal  <= 1'b0;
            r_id_br_taken <= 1'b0;
            r_id_br_addr  <= 32'h0;
        end else if (!i_stall) begin
            r_id_pc <= i_if_pc;
            if (w_bubble) begin
                r_id_insn     <= NOP_INSN;
                r_id_en       <= 1'b0;
                r_id_rs1      <= 5'd0;
                r_id_rs2      <= 5'd0;
                r_id_rd       <= 5'd0;
                r_id_imm      <= 32'h0;
                r_id_op       <= 3'd0;
                r_id_illegal  <= 1'b0;
                r_id_br_taken <= 1'b0;
                r_id_br_addr  <= 32'h0;
            end else begin
                r_id_insn     <= i_if_insn;
                r_id_en       <= 1'b1;
                r_id_rs1      <= w_rs1;
                r_id_rs2      <= w_rs2;
                r_id_rd       <= w_rd;
                r_id_imm      <= w_imm;
                r_id_op       <= w_op;
                r_id_illegal  <= w_illegal;
                r_id_br_taken <= w_is_jal;
                r_id_br_addr  <= w_is_jal ? w_jal_addr : 32'h0;
            end
        end
    end

    assign o_id_pc       = r_id_pc;
    assign o_id_insn     = r_id_insn;
    assign o_id_en       = r_id_en;
    assign o_id_rs1      = r_id_rs1;
    assign o_id_rs2      = r_id_rs2;
    assign o_id_rd       = r_id_rd;
    assign o_id_imm      = r_id_imm;
    assign o_id_op       = r_id_op;
    assign o_id_illegal  = r_id_illegal;
    assign o_id_br_taken = r_id_br_taken;
    assign o_id_br_addr  = r_id_br_addr;
    assign o_load_hazard = w_load_hazard;

endmodule

// File: tb/tb_id_reg.sv
// ---------------------------------------------------------------------------
// tb_id_reg : directed-vector bench for id_reg with a behavioural reference
// model; inputs change 1ns after each rising edge, the model advances on the
// rising edge and the full output set is compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_id_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, if_en, ex_load;
    logic [31:0] if_pc, if_insn;
    logic [4:0]  ex_rd;
    logic [31:0] id_pc, id_insn, id_imm, id_br_addr;
    logic        id_en, id_illegal, id_br_taken, load_hazard;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_op;

    int n_cmp = 0;
    int n_bad = 0;

    id_reg dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
        .i_if_pc(if_pc), .i_if_insn(if_insn), .i_if_en(if_en),
        .i_ex_load(ex_load), .i_ex_rd(ex_rd),
        .o_id_pc(id_pc), .o_id_insn(id_insn), .o_id_en(id_en),
        .o_id_rs1(id_rs1), .o_id_rs2(id_rs2), .o_id_rd(id_rd),
        .o_id_imm(id_imm), .o_id_op(id_op), .o_id_illegal(id_illegal),
        .o_id_br_taken(id_br_taken), .o_id_br_addr(id_br_addr),
        .o_load_hazard(load_hazard)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc, insn, imm, bra;
        logic        en, ill, brt;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  op;
    } exp_t;

    exp_t m;
    bit   m_valid = 0;

    function automatic exp_t m_bubble(input logic [31:0] pc);
        exp_t e;
        e.pc = pc; e.insn = 32'h13; e.imm = 0; e.bra = 0;
        e.en = 0; e.ill = 0; e.brt = 0; e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.op = 0;
        return e;
    endfunction

    // Immediates built with arithmetic shifts of the whole word.
    function automatic exp_t m_capture(input logic [31:0] pc, input logic [31:0] w);
        exp_t e;
        logic signed [31:0] s;
        logic [31:0] jimm;
        s = $signed(w);
        jimm = (32'(s >>> 31) << 20) | ({24'h0, w[19:12]} << 12) |
               ({31'h0, w[20]} << 11) | ({22'h0, w[30:21]} << 1);
        e = m_bubble(pc);
        e.insn = w; e.en = 1;
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        case (w[6:0])
            7'h33: e.op = 1;
            7'h13: begin e.op = 2; e.imm = 32'(s >>> 20); end
            7'h03: begin e.op = 3; e.imm = 32'(s >>> 20); end
            7'h23: begin e.op = 4; e.rd = 0;
                   e.imm = (32'(s >>> 25) << 5) | {27'h0, w[11:7]}; end
            7'h63: begin e.op = 5; e.rd = 0;
                   e.imm = (32'(s >>> 31) << 12) | ({31'h0, w[7]} << 11) |
                           ({26'h0, w[30:25]} << 5) | ({28'h0, w[11:8]} << 1); end
            7'h6F: begin e.op = 6; e.imm = jimm; e.brt = 1; e.bra = pc + jimm; end
            7'h67: begin e.op = 6; e.imm = 32'(s >>> 20); end
            7'h37, 7'h17: begin e.op = 7; e.imm = w & 32'hFFFF_F000; end
            default: begin e.op = 0; e.ill = 1; e.rd = 0; end
        endcase
        return e;
    endfunction

    function automatic logic m_hazard(input logic en, input logic exl,
                                      input logic [4:0] rd, input logic [31:0] w);
        logic u1, u2;
        u1 = (w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67});
        u2 = (w[6:0] inside {7'h33, 7'h23, 7'h63});
        return en && exl && rd != 0 &&
               ((u1 && w[19:15] == rd) || (u2 && w[24:20] == rd));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m = m_bubble(32'h0);
            m_valid = 1;
        end else if (m_valid && !stall) begin
            if (flush || m_hazard(if_en, ex_load, ex_rd, if_insn) || !if_en)
                m = m_bubble(if_pc);
            else
                m = m_capture(if_pc, if_insn);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_pc", id_pc, m.pc);
            chk("m_insn", id_insn, m.insn);
            chk("m_en", 32'(id_en), 32'(m.en));
            chk("m_rs1", 32'(id_rs1), 32'(m.rs1));
            chk("m_rs2", 32'(id_rs2), 32'(m.rs2));
            chk("m_rd", 32'(id_rd), 32'(m.rd));
            chk("m_imm", id_imm, m.imm);
            chk("m_op", 32'(id_op), 32'(m.op));
            chk("m_illegal", 32'(id_illegal), 32'(m.ill));
            chk("m_br_taken", 32'(id_br_taken), 32'(m.brt));
            chk("m_br_addr", id_br_addr, m.bra);
        end
        chk("m_hazard", 32'(load_hazard), 32'(m_hazard(if_en, ex_load, ex_rd, if_insn)));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rs, input logic st, input logic fl, input logic en,
                         input logic [31:0] pc, input logic [31:0] insn,
                         input logic exl, input logic [4:0] exrd);
        reset = rs; stall = st; flush = fl; if_en = en;
        if_pc = pc; if_insn = insn; ex_load = exl; ex_rd = exrd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] insn;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[6] = '{
        '{32'h123452B7, 3'd7, 5'd5, 32'h12345000},   // lui x5,0x12345
        '{32'hFFFFF317, 3'd7, 5'd6, 32'hFFFFF000},   // auipc x6,0xFFFFF
        '{32'hFFC42383, 3'd3, 5'd7, 32'hFFFFFFFC},   // lw x7,-4(x8)
        '{32'hFE208CE3, 3'd5, 5'd0, 32'hFFFFFFF8},   // beq x1,x2,-8
        '{32'h00C280E7, 3'd6, 5'd1, 32'h0000000C},   // jalr x1,12(x5)
        '{32'h002081B3, 3'd1, 5'd3, 32'h00000000}    // add x3,x1,x2
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        tick(); tick();
        chk("rst_insn", id_insn, 32'h13);
        chk("rst_en", 32'(id_en), 0);
        chk("rst_pc", id_pc, 0);

        // addi x1,x0,5
        drive(0, 0, 0, 1, 32'h100, 32'h00500093, 0, 0);
        tick();
        chk("addi_en", 32'(id_en), 1);
        chk("addi_op", 32'(id_op), 2);
        chk("addi_rd", 32'(id_rd), 1);
        chk("addi_rs1", 32'(id_rs1), 0);
        chk("addi_imm", id_imm, 5);

        // jal x0,+8 : one-cycle pulse
        drive(0, 0, 0, 1, 32'h200, 32'h0080006F, 0, 0);
        tick();
        chk("jal_brt", 32'(id_br_taken), 1);
        chk("jal_bra", id_br_addr, 32'h208);
        chk("jal_op", 32'(id_op), 6);
        drive(0, 0, 0, 1, 32'h204, 32'h00500093, 0, 0);
        tick();
        chk("jal_pulse", 32'(id_br_taken), 0);

        // load-use hazard on rs2
        drive(0, 0, 0, 1, 32'h208, 32'h002081B3, 1, 2);
        #1 chk("haz_comb", 32'(load_hazard), 1);
        tick();
        chk("haz_en", 32'(id_en), 0);
        chk("haz_insn", id_insn, 32'h13);
        ex_rd = 0;
        #1 chk("haz_rd0", 32'(load_hazard), 0);
        tick();
        chk("haz_rd0_en", 32'(id_en), 1);

        // sw x2,4(x1) then stall with changing inputs
        drive(0, 0, 0, 1, 32'h20C, 32'h0020A223, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, i[0], 1, 32'h400 + 32'(i * 4), 32'h00500093 + 32'(i << 7), 0, 0);
            tick();
            chk("stall_op", 32'(id_op), 4);
            chk("stall_imm", id_imm, 4);
            chk("stall_rd", 32'(id_rd), 0);
            chk("stall_pc", id_pc, 32'h20C);
        end

        // jal wrapping past 2^32, held across a stall
        drive(0, 0, 0, 1, 32'hFFFFFFFC, 32'h0080006F, 0, 0);
        tick();
        chk("wrap_bra", id_br_addr, 32'h4);
        drive(0, 1, 0, 0, 32'h0, 32'h0, 0, 0);
        tick(); tick();
        chk("stall_brt", 32'(id_br_taken), 1);

        // flush together with hazard
        drive(0, 0, 1, 1, 32'h300, 32'h002081B3, 1, 1);
        #1 chk("fl_haz", 32'(load_hazard), 1);
        tick();
        chk("fl_en", 32'(id_en), 0);
        chk("fl_brt", 32'(id_br_taken), 0);
        chk("fl_pc", id_pc, 32'h300);

        // if_en low -> bubble
        drive(0, 0, 0, 0, 32'h310, 32'h00500093, 0, 0);
        tick();
        chk("noen_insn", id_insn, 32'h13);

        // assorted types
        foreach (vecs[k]) begin
            drive(0, 0, 0, 1, 32'h1000 + 32'(k * 4), vecs[k].insn, 0, 0);
            tick();
            chk("vec_op", 32'(id_op), 32'(vecs[k].op));
            chk("vec_rd", 32'(id_rd), 32'(vecs[k].rd));
            chk("vec_imm", id_imm, vecs[k].imm);
            chk("vec_brt", 32'(id_br_taken), 0);
        end

        // illegal opcode
        drive(0, 0, 0, 1, 32'h500, 32'h0000007F, 0, 0);
        tick();
        chk("ill_ill", 32'(id_illegal), 1);
        chk("ill_op", 32'(id_op), 0);
        chk("ill_en", 32'(id_en), 1);

        // reset beats stall; hazard still evaluated during reset
        drive(1, 1, 0, 1, 32'h600, 32'h002081B3, 1, 2);
        #1 chk("rst_haz", 32'(load_hazard), 1);
        tick();
        chk("rst2_insn", id_insn, 32'h13);
        chk("rst2_en", 32'(id_en), 0);
        chk("rst2_ill", 32'(id_illegal), 0);
        chk("rst2_pc", id_pc, 0);

        drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_reg.md
ID_REG -- requirements
Module: id_reg

Interface
REQ-001 The block SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 The block SHALL have ports: stall  in  1  hold all ID/EX state.
REQ-004 The block SHALL have ports: flush  in  1  replace captured instruction with bubble.
REQ-005 The block SHALL have ports: if_pc  in  32  PC from IF/ID register.
REQ-006 The block SHALL have ports: if_insn  in  32  instruction from IF/ID register.
REQ-007 The block SHALL have ports: if_en  in  1  IF/ID data valid.
REQ-008 The block SHALL have ports: ex_load  in  1  EX stage holds valid load; ex_rd  in  5  its destination register.
REQ-009 The block SHALL have outputs: id_pc 32, id_insn 32, id_en 1, id_rs1 5, id_rs2 5, id_rd 5, id_imm 32, id_op 3, id_illegal 1, id_br_taken 1, id_br_addr 32, all registered.
REQ-010 The block SHALL have output: load_hazard  out  1  combinational stall request to IF/ID and PC logic.

Function
REQ-011 Update priority each edge SHALL be: reset > stall (hold all registers) > flush > load_hazard > if_en=0 > normal capture.
REQ-012 Bubble (flush, load_hazard or if_en=0) SHALL load id_pc<=if_pc, id_insn<=0x00000013 (NOP), id_en<=0, id_op<=0, id_illegal<=0, id_br_taken<=0, id_rs1/rs2/rd/imm<=0, id_br_addr<=0.
REQ-013 Normal capture SHALL load id_pc<=if_pc, id_insn<=if_insn, id_en<=1, fields decoded from if_insn; latency exactly one cycle.
REQ-014 Field decode SHALL be RV32I: rs1=[19:15], rs2=[24:20], rd=[11:7].
REQ-015 id_op SHALL encode opcode[6:0]: 0x33->1 OP, 0x13->2 OP-IMM, 0x03->3 LOAD, 0x23->4 STORE, 0x63->5 BRANCH, 0x6F/0x67->6 JUMP, 0x37/0x17->7 UPPER.
REQ-016 Any other opcode SHALL capture id_op=0, id_illegal=1, id_en=1, id_rd=0, id_imm=0.
REQ-017 id_imm SHALL be sign-extended per type: I (OP-IMM, LOAD, JALR), S (STORE), B (BRANCH, bit0=0), U (UPPER, low 12 bits 0), J (JAL, bit0=0); OP yields 0.
REQ-018 For STORE and BRANCH, id_rd SHALL be 0.
REQ-019 On capture of JAL (0x6F), id_br_taken SHALL be 1 and id_br_addr SHALL be if_pc + J-imm modulo 2^32 (wrap, no overflow flag); otherwise both 0.
REQ-020 id_br_taken SHALL be a single-cycle pulse unless stall holds it.
REQ-021 rs1 SHALL count as used for OP, OP-IMM, LOAD, STORE, BRANCH, JALR; rs2 for OP, STORE, BRANCH.
REQ-022 load_hazard SHALL be 1 iff if_en & ex_load & ex_rd!=0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)), evaluated on if_insn.
REQ-023 load_hazard SHALL be computed regardless of stall/flush; flush overrides it in the register update (bubble either way).
REQ-024 While stall=1, every output register SHALL hold its value, including id_br_taken.

Reset
REQ-025 With reset=1 at an edge, all outputs SHALL become 0 except id_insn=0x00000013; id_en=0.
REQ-026 Reset SHALL override stall, flush and hazard when asserted mid-operation.
REQ-027 load_hazard SHALL still evaluate combinationally during reset.

Verification
REQ-028 Reset, then if_en=1, if_pc=0x100, if_insn=0x00500093 (addi x1,x0,5) -> next cycle id_en=1, id_op=2, id_rd=1, id_rs1=0, id_imm=5.
REQ-029 if_pc=0x200, if_insn=0x0080006F (jal x0,+8) -> id_br_taken=1 one cycle, id_br_addr=0x208, id_op=6.
REQ-030 ex_load=1, ex_rd=2, if_insn=0x002081B3 (add x3,x1,x2) -> load_hazard=1 same cycle, next cycle id_en=0, id_insn=0x00000013; ex_rd=0 -> load_hazard=0.
REQ-031 Capture sw (0x0020A223), then stall=1 for 3 cycles with changing inputs -> outputs unchanged, id_op=4, id_imm=4, id_rd=0.
REQ-032 if_pc=0xFFFFFFFC, jal +8 -> id_br_addr=0x00000004; flush=1 simultaneous with hazard -> bubble, id_br_taken=0.
REQ-033 if_insn=0x0000007F -> id_illegal=1, id_op=0, id_en=1; reset asserted with stall=1 -> reset values next edge.
